// File: rtl/zc_sched_pkg.sv
// Shared types and constants for the zero-crossing event scheduler.
// Optional dead-time logic in the top is enabled with `define ZC_HOLDOFF_EN.
package zc_sched_pkg;

  localparam int DEF_NUM_CHANNELS = 16;
  localparam int DEF_LANE_BITS    = 4;
  localparam int DEF_TS_WIDTH     = 32;
  localparam int DEF_FIFO_DEPTH   = 4;

  // FIFO entry: {filtered mask, direction word, frame index}
  localparam int ENTRY_W = 2 * DEF_NUM_CHANNELS + DEF_TS_WIDTH - DEF_LANE_BITS;

  typedef enum logic [1:0] {
    DIR_BOTH = 2'b00,
    DIR_RISE = 2'b01,
    DIR_FALL = 2'b10,
    DIR_NONE = 2'b11
  } dir_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sched_state_e;

  // Scanning downwards leaves the index of the lowest set bit; 0 for an empty mask.
  function automatic logic [DEF_LANE_BITS-1:0] lowest_set(input logic [DEF_NUM_CHANNELS-1:0] mask);
    lowest_set = '0;
    for (int i = DEF_NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = DEF_LANE_BITS'(i);
    end
  endfunction

endpackage

// File: rtl/zc_mask_fifo.sv
// Synchronous mask-word FIFO; a push at full is accepted when a pop happens at the same edge.
module zc_mask_fifo
  import zc_sched_pkg::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && !clear && (!full || pop);
  assign rd_en = pop && !clear && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/zc_event_scheduler.sv
// Serialises buffered zero-crossing mask words into a one-event-per-cycle timestamped stream.
// `define ZC_HOLDOFF_EN adds a dead time that silently drops events too close to the last one.
module zc_event_scheduler
  import zc_sched_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int LANE_BITS    = DEF_LANE_BITS,
  parameter int TS_WIDTH     = DEF_TS_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
`ifdef ZC_HOLDOFF_EN
  , parameter int HOLDOFF_SAMPLES = 8
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_clear,
  input  logic                    enable,
  input  logic [1:0]              dir_select,
  input  logic                    valid_in,
  input  logic [NUM_CHANNELS-1:0] zero_mask_in,
  input  logic [NUM_CHANNELS-1:0] zero_dir_in,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [TS_WIDTH-1:0]     evt_timestamp,
  output logic [LANE_BITS-1:0]    evt_lane,
  output logic                    evt_dir,
  output logic                    evt_last,
  output logic [15:0]             overflow_cnt,
  output logic                    busy
);

  localparam int FW = TS_WIDTH - LANE_BITS;
  localparam int EW = 2 * NUM_CHANNELS + FW;

  sched_state_e          state_q, state_d;
  logic [FW-1:0]         frame_cnt;
  logic [NUM_CHANNELS-1:0] sel, fm;
  logic                  push_req, fifo_push, drop, pop, consume, suppress;
  logic                  fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_rd;
  logic [NUM_CHANNELS-1:0] work_mask, work_dir, rest_mask;
  logic [FW-1:0]         work_frame;
  logic [LANE_BITS-1:0]  lane;
  logic [TS_WIDTH-1:0]   cand_ts;
  logic                  in_emit, last_bit;

  always_comb begin
    sel = '1;
    case (dir_sel_e'(dir_select))
      DIR_RISE: sel = zero_dir_in;
      DIR_FALL: sel = ~zero_dir_in;
      DIR_NONE: sel = '0;
      default:  sel = '1;
    endcase
    fm = zero_mask_in & sel;
  end

  assign push_req  = valid_in && enable && (fm != '0) && !sync_clear;
  assign fifo_push = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  zc_mask_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (sync_clear),
    .push    (fifo_push),
    .pop     (pop),
    .wr_data ({fm, zero_dir_in, frame_cnt}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_emit   = (state_q == EMIT);
  assign lane      = lowest_set(work_mask);
  assign rest_mask = work_mask & (work_mask - NUM_CHANNELS'(1));
  assign last_bit  = (rest_mask == '0);
  assign cand_ts   = {work_frame, lane};

`ifdef ZC_HOLDOFF_EN
  logic [TS_WIDTH-1:0] last_ts;
  logic                last_ts_vld;

  // Modulo distance keeps the dead time correct across timestamp wrap.
  assign suppress = in_emit && last_ts_vld &&
                    ((cand_ts - last_ts) < TS_WIDTH'(HOLDOFF_SAMPLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ts     <= '0;
      last_ts_vld <= 1'b0;
    end else if (sync_clear) begin
      last_ts     <= '0;
      last_ts_vld <= 1'b0;
    end else if (evt_valid && evt_ready) begin
      last_ts     <= cand_ts;
      last_ts_vld <= 1'b1;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    consume   = 1'b0;
    evt_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        evt_valid = !suppress;
        consume   = suppress || evt_ready;
        if (consume && last_bit) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sync_clear) begin
      state_d = IDLE;
      pop     = 1'b0;
      consume = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_cnt    <= '0;
      overflow_cnt <= '0;
      work_mask    <= '0;
      work_dir     <= '0;
      work_frame   <= '0;
    end else begin
      state_q <= state_d;
      if (sync_clear) begin
        frame_cnt    <= '0;
        overflow_cnt <= '0;
        work_mask    <= '0;
        work_dir     <= '0;
        work_frame   <= '0;
      end else begin
        if (valid_in) frame_cnt <= frame_cnt + FW'(1);
        if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        if (pop) begin
          work_mask  <= fifo_rd[EW-1 -: NUM_CHANNELS];
          work_dir   <= fifo_rd[FW +: NUM_CHANNELS];
          work_frame <= fifo_rd[FW-1:0];
        end else if (consume) begin
          work_mask  <= rest_mask;
        end
      end
    end
  end

  assign evt_timestamp = in_emit ? cand_ts : '0;
  assign evt_lane      = in_emit ? lane : '0;
  assign evt_dir       = in_emit && work_dir[lane];
  assign evt_last      = in_emit && last_bit;
  assign busy          = !fifo_empty || in_emit;

endmodule

// File: tb/tb_zc_event_scheduler.sv
// Directed self-checking bench for zc_event_scheduler; holdoff case runs when ZC_HOLDOFF_EN is defined.
module tb_zc_event_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_clear, enable, valid_in, evt_ready;
  logic [1:0]  dir_select;
  logic [15:0] zero_mask_in, zero_dir_in;
  logic        evt_valid, evt_dir, evt_last, busy;
  logic [31:0] evt_timestamp;
  logic [3:0]  evt_lane;
  logic [15:0] overflow_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  zc_event_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_clear    (sync_clear),
    .enable        (enable),
    .dir_select    (dir_select),
    .valid_in      (valid_in),
    .zero_mask_in  (zero_mask_in),
    .zero_dir_in   (zero_dir_in),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_timestamp (evt_timestamp),
    .evt_lane      (evt_lane),
    .evt_dir       (evt_dir),
    .evt_last      (evt_last),
    .overflow_cnt  (overflow_cnt),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] mask, input logic [15:0] dir);
    valid_in     = 1'b1;
    zero_mask_in = mask;
    zero_dir_in  = dir;
    tick();
    valid_in     = 1'b0;
  endtask

  task automatic expect_evt(input string tag, input logic [31:0] ts, input logic [3:0] ln,
                            input logic dr, input logic lst);
    check({tag, ".valid"}, evt_valid, 1'b1);
    check({tag, ".ts"},    evt_timestamp, ts);
    check({tag, ".lane"},  evt_lane, ln);
    check({tag, ".dir"},   evt_dir, dr);
    check({tag, ".last"},  evt_last, lst);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, evt_valid, 1'b0);
    check({tag, ".busy"},  busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; sync_clear = 1'b0; enable = 1'b1; valid_in = 1'b0; evt_ready = 1'b1;
    dir_select = 2'b00; zero_mask_in = '0; zero_dir_in = '0;
    #12;
    check("rst.valid", evt_valid, 1'b0);
    check("rst.ts",    evt_timestamp, 32'd0);
    check("rst.ovf",   overflow_cnt, 16'd0);
    check("rst.busy",  busy, 1'b0);
    #3 rst_n = 1'b1;
    tick();

    // Frames 0..2 pass with capture disabled: counter advances, nothing stored.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send(16'hFFFF, 16'h0000);
    check("dis.busy", busy, 1'b0);
    enable = 1'b1;

    // Frame 3, both directions: 0x8005 -> lanes 0, 2, 15
    send(16'h8005, 16'h0001);
    check("lat.valid", evt_valid, 1'b0);
    check("lat.busy",  busy, 1'b1);
    tick(); expect_evt("both0", 32'd48, 4'd0, 1'b1, 1'b0);
    tick(); expect_evt("both1", 32'd50, 4'd2, 1'b0, 1'b0);
    tick(); expect_evt("both2", 32'd63, 4'd15, 1'b0, 1'b1);
    tick(); expect_idle("both_end");

    // Frame 4, rising only: lane 0
    dir_select = 2'b01;
    send(16'h8005, 16'h0001);
    tick(); expect_evt("rise0", 32'd64, 4'd0, 1'b1, 1'b1);
    tick(); expect_idle("rise_end");

    // Frame 5, falling only: lanes 2, 15
    dir_select = 2'b10;
    send(16'h8005, 16'h0001);
    tick(); expect_evt("fall0", 32'd82, 4'd2, 1'b0, 1'b0);
    tick(); expect_evt("fall1", 32'd95, 4'd15, 1'b0, 1'b1);
    tick(); expect_idle("fall_end");

    // Frame 6, no direction: nothing stored
    dir_select = 2'b11;
    send(16'h8005, 16'h0001);
    check("none.busy", busy, 1'b0);
    tick(); expect_idle("none_end");
    dir_select = 2'b00;

    // Frame 7 with ready low, three lanes pending, then async reset
    evt_ready = 1'b0;
    send(16'h0007, 16'h0000);
    tick(); expect_evt("pend", 32'd112, 4'd0, 1'b0, 1'b0);
    tick(); expect_evt("hold", 32'd112, 4'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", evt_valid, 1'b0);
    check("arst.ts",    evt_timestamp, 32'd0);
    check("arst.lane",  evt_lane, 4'd0);
    check("arst.last",  evt_last, 1'b0);
    check("arst.busy",  busy, 1'b0);
    #2 rst_n = 1'b1;
    tick(); expect_idle("arst_rel");

    // Backpressure: six words, four FIFO slots plus the working register
    for (int k = 0; k < 6; k++) begin
      valid_in = 1'b1; zero_mask_in = 16'h0001; zero_dir_in = 16'h0000;
      tick();
    end
    valid_in = 1'b0;
    check("bp.ovf", overflow_cnt, 16'd1);
    expect_evt("bp.hold", 32'd0, 4'd0, 1'b0, 1'b1);
    tick();
    expect_evt("bp.hold2", 32'd0, 4'd0, 1'b0, 1'b1);
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_evt($sformatf("bp%0d", k), 32'(16 * k), 4'd0, 1'b0, 1'b1);
      tick();
    end
    expect_idle("bp_end");

    // Frame 6 pending under ready low, then sync_clear with a concurrent word
    evt_ready = 1'b0;
    send(16'h0010, 16'h0000);
    tick(); expect_evt("clr.pend", 32'd100, 4'd4, 1'b0, 1'b1);
    check("clr.ovf_before", overflow_cnt, 16'd1);
    sync_clear = 1'b1; valid_in = 1'b1; zero_mask_in = 16'h0002;
    tick();
    sync_clear = 1'b0; valid_in = 1'b0;
    check("clr.valid", evt_valid, 1'b0);
    check("clr.ovf",   overflow_cnt, 16'd0);
    check("clr.busy",  busy, 1'b0);
    tick(); expect_idle("clr.discard");
    evt_ready = 1'b1;
    send(16'h0010, 16'h0000);
    tick(); expect_evt("clr.next", 32'd4, 4'd4, 1'b0, 1'b1);
    tick(); expect_idle("clr_end");

`ifdef ZC_HOLDOFF_EN
    // Frame 1, last emitted ts 4: lanes 1 and 4 fall within 8 samples of lane 0
    send(16'h0213, 16'h0000);
    tick(); expect_evt("ho.l0", 32'd16, 4'd0, 1'b0, 1'b0);
    tick(); check("ho.l1", evt_valid, 1'b0);
    tick(); check("ho.l4", evt_valid, 1'b0);
    tick(); expect_evt("ho.l9", 32'd25, 4'd9, 1'b0, 1'b1);
    tick(); expect_idle("ho_end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zc_event_scheduler.md
Name: zc_event_scheduler

Overview:
Consumes the per-cycle 16-bit zero-crossing mask and direction words from the zero-crossing mask stage and serialises them into a single event stream. The stream carries one crossing per cycle with an absolute sample timestamp, lane and direction. It buffers mask words in a small FIFO, arbitrates lanes earliest-first (ch0 before ch15) and applies valid/ready backpressure. It sits between the zero-crossing mask stage and the downstream peak/timing logic.

Parameters:
NUM_CHANNELS, 16, lanes per word (power of two)
LANE_BITS, 4, log2(NUM_CHANNELS)
TS_WIDTH, 32, event timestamp width in samples
FIFO_DEPTH, 4, buffered mask words (power of two, >=2)
HOLDOFF_SAMPLES, 8, dead time in samples (used only with ZC_HOLDOFF_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sync_clear  in  1  synchronous flush of FIFO, working word, frame counter, overflow_cnt
enable  in  1  capture enable; the frame counter runs regardless
dir_select  in  2  00 both directions, 01 rising only (dir=1), 10 falling only, 11 none
valid_in  in  1  mask word valid
zero_mask_in  in  NUM_CHANNELS  crossing mask, bit i = lane i
zero_dir_in  in  NUM_CHANNELS  per-lane direction, 1 = rising
evt_valid  out  1  event valid
evt_ready  in  1  downstream ready
evt_timestamp  out  TS_WIDTH  frame_index*NUM_CHANNELS + lane, modulo 2^TS_WIDTH
evt_lane  out  LANE_BITS  lane index
evt_dir  out  1  crossing direction
evt_last  out  1  final event of its mask word
overflow_cnt  out  16  words dropped on FIFO full, saturates at 0xFFFF
busy  out  1  FIFO non-empty or working word loaded

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0. FIFO empty, frame counter 0, state IDLE.
- Clock and reset: clk is the clock. rst_n is an asynchronous, active-low reset.
- Frame counter (TS_WIDTH-LANE_BITS bits) increments on every valid_in and wraps silently. The word sampled with counter value F carries frame index F.
- Filter: fm = zero_mask_in & sel, where sel = zero_dir_in for 01, ~zero_dir_in for 10, all-ones for 00, zero for 11.
- Push: on valid_in && enable && fm!=0, write {fm, zero_dir_in, F}. Words with fm==0 are never stored.
- Full FIFO: push is accepted if a pop occurs at the same edge. Otherwise the word is dropped and overflow_cnt increments (saturating).
- FSM IDLE: if the FIFO is non-empty, pop into the working register and go to EMIT.
- FSM EMIT: outputs are driven from the working register; lane = lowest set bit of the remaining mask.
  - evt_valid=1. evt_last=1 when exactly one bit remains.
  - On evt_valid && evt_ready, clear that bit.
  - If the cleared bit was the last, pop the next word at the same edge (no bubble), or return to IDLE if the FIFO is empty.
  - Outputs hold stable while evt_ready is low.
- Latency: word sampled at edge E is written at E, loaded at E+1, and visible on evt_valid after E+1.
- Throughput: 1 event/cycle with evt_ready held high.
- sync_clear has priority over push, pop and count. It empties the FIFO, returns to IDLE, sets overflow_cnt=0 and counter=0. A concurrent valid_in word is discarded. The next valid_in gets frame index 0.
- enable low does not stop emission of already-buffered words.

Optional Feature:
ZC_HOLDOFF_EN:
- Defined: the block keeps the last emitted timestamp T (invalid after reset/clear). In EMIT, if the candidate timestamp minus T (modulo) is < HOLDOFF_SAMPLES, the bit is cleared without asserting evt_valid. This costs one cycle. evt_last semantics and the pop rules are otherwise unchanged. If the discarded bit was the word's last, pop or IDLE follows as normal.
- Undefined: no dead-time logic and no T register.

Decomposition:
- Package zc_sched_pkg: NUM_CHANNELS/LANE_BITS defaults, dir_select encodings (DIR_BOTH, DIR_RISE, DIR_FALL, DIR_NONE), FSM state enum (IDLE, EMIT), FIFO entry width constant.
- Sub-module zc_mask_fifo: synchronous FIFO with push/pop/full/empty and simultaneous push+pop at full.
- Lowest-set-bit encoder: a function in the package.

Test Plan:
- Reset mid-EMIT with 3 bits pending -> all outputs 0 immediately; after release busy=0 and evt_valid=0.
- Frame 3, mask 0x8005, dir 0x0001, dir_select 00, ready high -> three events: (ts 48, lane 0, dir 1), (50, 2, 0), (63, 15, 0, last=1) on consecutive cycles.
- Same word with dir_select 01 -> single event ts 48, lane 0, last=1; with 11 -> no events, busy stays 0.
- evt_ready low, six consecutive valid_in words with mask 0x0001 -> word 1 in the working register, words 2-5 in the FIFO, word 6 dropped, overflow_cnt=1. Releasing ready yields 5 events, ts 0,16,32,48,64.
- sync_clear asserted with a word pending and valid_in high -> evt_valid=0 next cycle, overflow_cnt=0; next valid word mask 0x0010 -> ts 4.
- ZC_HOLDOFF_EN, HOLDOFF_SAMPLES=8, mask 0x0213 -> events lanes 0 and 9 only; lanes 1 and 4 are suppressed.
